// File: rtl/sensor_pkg.sv
// Shared parameters, FSM state encoding and a saturating counter helper for the
// temperature history block.
package sensor_pkg;

  localparam int unsigned DEPTH   = 200;  // history entries
  localparam int unsigned WIDTH   = 8;    // sample width in bits
  localparam int unsigned CNT_W   = 8;    // request / count field width
  localparam int unsigned AGE_W   = 16;   // internal age arithmetic width
  localparam int unsigned AGE_MAX = 2 ** (AGE_W - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Saturates well below the top of the range so age sums never wrap.
  function automatic logic [AGE_W-1:0] sat_inc(input logic [AGE_W-1:0] x);
    return (x >= AGE_W'(AGE_MAX)) ? x : x + AGE_W'(1);
  endfunction

endpackage

// File: rtl/temp_ring_buffer.sv
// Circular sample store with one write port and one combinational read port
// addressed by age (0 = newest).
//   clock, reset      : rising-edge clock, synchronous active-high reset
//   wr_en, wr_data    : append a sample, advancing wr_ptr
//   rd_age -> rd_data : sample at slot (wr_ptr-1-rd_age) mod DEPTH
//   stored_count      : valid entries, saturating at DEPTH
module temp_ring_buffer #(
  parameter int unsigned DEPTH = sensor_pkg::DEPTH,
  parameter int unsigned WIDTH = sensor_pkg::WIDTH
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        wr_en,
  input  logic [WIDTH-1:0]            wr_data,
  input  logic [sensor_pkg::AGE_W-1:0] rd_age,
  output logic [WIDTH-1:0]            rd_data,
  output logic [sensor_pkg::CNT_W-1:0] stored_count
);
  import sensor_pkg::*;

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  int unsigned      age_mod;
  int unsigned      slot;

  // Storage is never reset; stored_count gates what is readable.
  always_ff @(posedge clock) begin
    if (wr_en && !reset) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Write pointer and occupancy.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr       <= '0;
      stored_count <= '0;
    end else if (wr_en) begin
      wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      if (stored_count != CNT_W'(DEPTH)) begin
        stored_count <= stored_count + CNT_W'(1);
      end
    end
  end

  // Age-to-slot translation; ages past DEPTH fold back modulo DEPTH.
  always_comb begin
    age_mod = 32'(rd_age) % DEPTH;
    slot    = (32'(wr_ptr) + DEPTH - 32'd1 - age_mod) % DEPTH;
    rd_data = mem[PTR_W'(slot)];
  end

endmodule

// File: rtl/temp_history_reader.sv
// Temperature history recorder with a dump engine: accepts a request for a
// window of past samples (offset/count by age), streams them newest first
// over a valid/ready port, then pulses a one-cycle summary.
//   clock, reset                 : rising-edge clock, synchronous active-high reset
//   sample_in, sample_valid      : sample write port (active during dumps too)
//   req_valid/ready/offset/count : dump request handshake
//   out_data/valid/ready/last    : returned sample stream
//   stats_valid/count, min_temp,
//   max_temp, overrun            : dump summary, valid for one cycle
//   stored_count                 : valid entries, saturating at DEPTH
module temp_history_reader #(
  parameter int unsigned DEPTH = sensor_pkg::DEPTH,
  parameter int unsigned WIDTH = sensor_pkg::WIDTH
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [WIDTH-1:0]             sample_in,
  input  logic                         sample_valid,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [sensor_pkg::CNT_W-1:0] req_offset,
  input  logic [sensor_pkg::CNT_W-1:0] req_count,
  output logic [WIDTH-1:0]             out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_last,
  output logic                         stats_valid,
  output logic [sensor_pkg::CNT_W-1:0] stats_count,
  output logic [WIDTH-1:0]             min_temp,
  output logic [WIDTH-1:0]             max_temp,
  output logic                         overrun,
  output logic [sensor_pkg::CNT_W-1:0] stored_count
);
  import sensor_pkg::*;

  state_t            state;
  state_t            state_next;

  logic              accept;
  logic              beat_xfer;
  logic              last_xfer;
  logic [CNT_W-1:0]  avail;
  logic [CNT_W-1:0]  n_eff;
  logic [AGE_W-1:0]  rd_age;
  logic [WIDTH-1:0]  rd_data;
  logic [WIDTH-1:0]  next_min;
  logic [WIDTH-1:0]  next_max;
  logic [AGE_W-1:0]  ovr_thr;
  logic              ovr_hit;

  logic [CNT_W-1:0]  off_q;
  logic [CNT_W-1:0]  n_q;
  logic [CNT_W-1:0]  idx_q;
  logic [AGE_W-1:0]  shift_q;   // writes since the snapshot, for re-addressing
  logic [AGE_W-1:0]  w_q;       // writes while streaming, for overrun
  logic [WIDTH-1:0]  run_min;
  logic [WIDTH-1:0]  run_max;

  temp_ring_buffer #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_ring (
    .clock        (clock),
    .reset        (reset),
    .wr_en        (sample_valid),
    .wr_data      (sample_in),
    .rd_age       (rd_age),
    .rd_data      (rd_data),
    .stored_count (stored_count)
  );

  // Request decode: effective count clipped to what the snapshot holds.
  always_comb begin
    accept    = (state == IDLE) && req_valid;
    beat_xfer = (state == STREAM) && out_ready;
    last_xfer = beat_xfer && out_last;
    avail     = stored_count - req_offset;
    n_eff     = '0;
    if (req_offset < stored_count) begin
      n_eff = (req_count < avail) ? req_count : avail;
    end
  end

  // Read address: the request offset at acceptance, otherwise the next beat's
  // snapshot age shifted by the writes that have landed since.
  always_comb begin
    rd_age = AGE_W'(req_offset);
    if (state != IDLE) begin
      rd_age = AGE_W'(off_q) + AGE_W'(idx_q) + AGE_W'(1) + shift_q;
    end
  end

  // Running extrema including the beat transferring now; overrun threshold.
  always_comb begin
    next_min = (out_data < run_min) ? out_data : run_min;
    next_max = (out_data > run_max) ? out_data : run_max;
    ovr_thr  = AGE_W'(DEPTH) - AGE_W'(off_q) - AGE_W'(n_q) + AGE_W'(1);
    ovr_hit  = (w_q >= ovr_thr);
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_valid) state_next = (n_eff == '0) ? DONE : STREAM;
      STREAM:  if (last_xfer) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    req_ready   = (state == IDLE);
    out_valid   = (state == STREAM);
    stats_valid = (state == DONE);
  end

  // Dump datapath: beat loading, write tracking and summary capture.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_data    <= '0;
      out_last    <= 1'b0;
      stats_count <= '0;
      min_temp    <= '0;
      max_temp    <= '0;
      overrun     <= 1'b0;
      off_q       <= '0;
      n_q         <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      w_q         <= '0;
      run_min     <= '0;
      run_max     <= '0;
    end else if (accept) begin
      off_q    <= req_offset;
      n_q      <= n_eff;
      idx_q    <= '0;
      shift_q  <= sample_valid ? AGE_W'(1) : '0;
      w_q      <= '0;
      run_min  <= '1;
      run_max  <= '0;
      out_data <= rd_data;
      out_last <= (n_eff == CNT_W'(1));
      if (n_eff == '0) begin
        stats_count <= '0;
        min_temp    <= '0;
        max_temp    <= '0;
        overrun     <= 1'b0;
      end
    end else if (state == STREAM) begin
      if (sample_valid) begin
        shift_q <= sat_inc(shift_q);
        w_q     <= sat_inc(w_q);
      end
      if (beat_xfer) begin
        run_min <= next_min;
        run_max <= next_max;
        if (out_last) begin
          out_last    <= 1'b0;
          stats_count <= n_q;
          min_temp    <= next_min;
          max_temp    <= next_max;
          overrun     <= ovr_hit;
        end else begin
          idx_q    <= idx_q + CNT_W'(1);
          out_data <= rd_data;
          out_last <= ((idx_q + CNT_W'(1)) == (n_q - CNT_W'(1)));
        end
      end
    end
  end

endmodule

// File: tb/tb_temp_history_reader.sv
// Scoreboard bench for temp_history_reader: directed dumps push expected beats
// and summaries into queues; a negedge monitor pops and compares them.
module tb_temp_history_reader;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] sample_in = '0;
  logic       sample_valid = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [7:0] req_offset = '0;
  logic [7:0] req_count = '0;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       out_last;
  logic       stats_valid;
  logic [7:0] stats_count;
  logic [7:0] min_temp;
  logic [7:0] max_temp;
  logic       overrun;
  logic [7:0] stored_count;

  always #5 clock = ~clock;

  temp_history_reader dut (
    .clock        (clock),
    .reset        (reset),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_offset   (req_offset),
    .req_count    (req_count),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_last     (out_last),
    .stats_valid  (stats_valid),
    .stats_count  (stats_count),
    .min_temp     (min_temp),
    .max_temp     (max_temp),
    .overrun      (overrun),
    .stored_count (stored_count)
  );

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } beat_t;

  typedef struct packed {
    logic [7:0] cnt;
    logic [7:0] mn;
    logic [7:0] mx;
    logic       ovr;
  } stats_t;

  beat_t  beat_q[$];
  stats_t stats_q[$];
  int     checks = 0;
  int     errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a beat or summary.
  bit    held = 1'b0;
  beat_t held_b;
  always @(negedge clock) begin
    beat_t  b;
    stats_t s;
    if (held && out_valid) begin
      chk("hold_data", out_data, held_b.data);
      chk("hold_last", out_last, held_b.last);
    end
    held        = out_valid && !out_ready;
    held_b.data = out_data;
    held_b.last = out_last;
    if (out_valid && out_ready) begin
      if (beat_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got data %0d, none expected", out_data);
      end else begin
        b = beat_q.pop_front();
        chk("beat_data", out_data, b.data);
        chk("beat_last", out_last, b.last);
      end
    end
    if (stats_valid) begin
      if (stats_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_stats: got count %0d, none expected", stats_count);
      end else begin
        s = stats_q.pop_front();
        chk("stats_count", stats_count, s.cnt);
        chk("min_temp", min_temp, s.mn);
        chk("max_temp", max_temp, s.mx);
        chk("overrun", overrun, s.ovr);
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic write1(input logic [7:0] v);
    sample_valid = 1'b1;
    sample_in    = v;
    step();
    sample_valid = 1'b0;
  endtask

  task automatic exp_beat(input logic [7:0] d, input logic l);
    beat_t b;
    b.data = d;
    b.last = l;
    beat_q.push_back(b);
  endtask

  task automatic exp_stats(input logic [7:0] c, input logic [7:0] mn,
                           input logic [7:0] mx, input logic o);
    stats_t s;
    s.cnt = c;
    s.mn  = mn;
    s.mx  = mx;
    s.ovr = o;
    stats_q.push_back(s);
  endtask

  // One-cycle request; optionally writes a sample in the acceptance cycle.
  task automatic request(input logic [7:0] off, input logic [7:0] cnt,
                         input logic wr, input logic [7:0] wv);
    @(negedge clock);
    chk("req_ready_idle", req_ready, 1);
    step();
    req_valid    = 1'b1;
    req_offset   = off;
    req_count    = cnt;
    sample_valid = wr;
    sample_in    = wv;
    step();
    req_valid    = 1'b0;
    sample_valid = 1'b0;
  endtask

  task automatic wait_stats();
    int n    = 0;
    bit seen = 1'b0;
    while (!seen && n < 2000) begin
      @(negedge clock);
      n++;
      if (stats_valid) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL stats_timeout: got no stats_valid after %0d cycles", n);
    end
  endtask

  task automatic chk_drained();
    @(negedge clock);
    chk("beats_drained", beat_q.size(), 0);
    chk("stats_drained", stats_q.size(), 0);
  endtask

  initial begin
    int nstats;

    // Reset state.
    do_reset();
    @(negedge clock);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_stats_valid", stats_valid, 0);
    chk("rst_stored_count", stored_count, 0);
    chk("rst_min_max", {min_temp, max_temp}, 0);
    chk("rst_overrun", overrun, 0);

    // Window in the middle of a short history.
    step();
    write1(8'd10);
    write1(8'd20);
    write1(8'd30);
    write1(8'd40);
    @(negedge clock);
    chk("stored_after_4", stored_count, 4);
    exp_beat(8'd30, 1'b0);
    exp_beat(8'd20, 1'b1);
    exp_stats(8'd2, 8'd20, 8'd30, 1'b0);
    request(8'd1, 8'd2, 1'b0, 8'd0);
    @(negedge clock);
    chk("first_beat_t1", out_valid, 1);
    wait_stats();
    @(negedge clock);
    chk("stats_valid_one_cycle", stats_valid, 0);
    chk("min_temp_held", min_temp, 20);
    chk("beats_drained", beat_q.size(), 0);

    // Count clipped to history; offset past history gives an empty dump.
    do_reset();
    write1(8'd5);
    write1(8'd6);
    write1(8'd7);
    exp_beat(8'd7, 1'b0);
    exp_beat(8'd6, 1'b0);
    exp_beat(8'd5, 1'b1);
    exp_stats(8'd3, 8'd5, 8'd7, 1'b0);
    request(8'd0, 8'd50, 1'b0, 8'd0);
    wait_stats();
    chk_drained();
    exp_stats(8'd0, 8'd0, 8'd0, 1'b0);
    request(8'd5, 8'd10, 1'b0, 8'd0);
    wait_stats();
    chk_drained();

    // Wrapped, saturated buffer: full dump.
    do_reset();
    for (int i = 0; i < 250; i++) write1(8'(i));
    @(negedge clock);
    chk("stored_saturated", stored_count, 200);
    for (int k = 0; k < 200; k++) exp_beat(8'(249 - k), (k == 199));
    exp_stats(8'd200, 8'd50, 8'd249, 1'b0);
    request(8'd0, 8'd200, 1'b0, 8'd0);
    wait_stats();
    chk_drained();

    // Backpressure with a write overwriting the oldest requested entry.
    out_ready = 1'b0;
    for (int k = 0; k < 199; k++) exp_beat(8'(249 - k), 1'b0);
    exp_beat(8'd7, 1'b1);
    exp_stats(8'd200, 8'd7, 8'd249, 1'b1);
    request(8'd0, 8'd200, 1'b0, 8'd0);
    step();
    write1(8'd7);
    step();
    step();
    @(negedge clock);
    chk("stall_out_valid", out_valid, 1);
    chk("stall_stored", stored_count, 200);
    step();
    out_ready = 1'b1;
    wait_stats();
    chk_drained();

    // Sample written in the acceptance cycle is excluded.
    do_reset();
    write1(8'd1);
    write1(8'd2);
    write1(8'd3);
    exp_beat(8'd3, 1'b0);
    exp_beat(8'd2, 1'b0);
    exp_beat(8'd1, 1'b1);
    exp_stats(8'd3, 8'd1, 8'd3, 1'b0);
    request(8'd0, 8'd3, 1'b1, 8'd99);
    wait_stats();
    chk_drained();
    chk("stored_incl_accept_write", stored_count, 4);

    // Reset while streaming aborts the dump.
    out_ready = 1'b0;
    request(8'd0, 8'd3, 1'b0, 8'd0);
    @(negedge clock);
    chk("abort_streaming", out_valid, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clock);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_stored", stored_count, 0);
    chk("abort_req_ready", req_ready, 1);
    out_ready = 1'b1;
    nstats = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (stats_valid || out_valid) nstats++;
    end
    chk("no_activity_after_abort", nstats, 0);
    chk_drained();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/temp_history_reader.md
TEMP_HISTORY_READER -- requirements
Module: temp_history_reader

Interface
REQ-001 The block SHALL have parameter DEPTH, default 200, meaning number of history entries.
REQ-002 The block SHALL have parameter WIDTH, default 8, meaning sample width in bits.
REQ-003 The block SHALL have port clock  in  1  rising-edge clock.
REQ-004 The block SHALL have port reset  in  1  reset, synchronous, active-high.
REQ-005 The block SHALL have port sample_in  in  WIDTH  temperature sample.
REQ-006 The block SHALL have port sample_valid  in  1  write sample_in this cycle.
REQ-007 The block SHALL have port req_valid  in  1  dump request present.
REQ-008 The block SHALL have port req_ready  out  1  request accepted when req_valid and req_ready are both high.
REQ-009 The block SHALL have port req_offset  in  8  age of first returned sample (0 = newest).
REQ-010 The block SHALL have port req_count  in  8  requested number of samples.
REQ-011 The block SHALL have ports out_data (out, WIDTH), out_valid (out, 1), out_ready (in, 1) and out_last (out, 1), forming the stream of returned samples.
REQ-012 The block SHALL have ports stats_valid (out, 1), stats_count (out, 8), min_temp (out, WIDTH), max_temp (out, WIDTH) and overrun (out, 1), forming the dump summary.
REQ-013 The block SHALL have port stored_count  out  8  number of valid entries, saturating at DEPTH.

Function
REQ-014 The block SHALL write sample_in into a circular buffer and advance the write pointer every cycle sample_valid=1, including during a dump; the pointer wraps from DEPTH-1 to 0.
REQ-015 Entry age k SHALL be the entry at slot (wr_ptr-1-k) mod DEPTH.
REQ-016 stored_count SHALL increment on each write and hold at DEPTH.
REQ-017 The block SHALL implement states IDLE, STREAM and DONE; req_ready SHALL equal 1 only in IDLE.
REQ-018 On acceptance at cycle T, the block SHALL snapshot wr_ptr and stored_count, excluding any sample written in cycle T.
REQ-019 Effective count N SHALL be min(req_count, snapshot_count-req_offset) when req_offset < snapshot_count, and 0 otherwise.
REQ-020 If N=0, the block SHALL go IDLE->DONE and emit no beats.
REQ-021 If N>0, the block SHALL go IDLE->STREAM and present ages req_offset .. req_offset+N-1, newest first, with out_valid=1 first at T+1.
REQ-022 A beat SHALL transfer when out_valid=1 and out_ready=1; the block SHALL sustain one beat per cycle while out_ready=1.
REQ-023 While out_valid=1 and out_ready=0, out_data and out_last SHALL hold stable.
REQ-024 out_last SHALL be 1 only on beat N.
REQ-025 On transfer of the last beat, the block SHALL go STREAM->DONE and deassert out_valid in the next cycle.
REQ-026 DONE SHALL last exactly one cycle, with stats_valid=1, and SHALL then go to IDLE.
REQ-027 In the DONE cycle, stats_count SHALL equal N, and min_temp/max_temp SHALL be the unsigned min/max of the transferred beats, or 0/0 when N=0.
REQ-028 Each write during STREAM SHALL increment a counter W; overrun SHALL be set when W >= DEPTH-(req_offset+N-1) before the last beat transfers.
REQ-029 overrun SHALL be reported in DONE; streaming SHALL continue regardless of overrun.
REQ-030 Outside DONE, stats_valid SHALL be 0; stats_count, min_temp, max_temp and overrun SHALL hold their last values.

Reset
REQ-031 Reset SHALL force IDLE and set out_valid, out_last, stats_valid, overrun, stats_count, min_temp, max_temp, stored_count and wr_ptr to 0, and req_ready to 1 in the following cycle.
REQ-032 Reset during STREAM SHALL abort the dump with no further beats and no stats pulse.
REQ-033 Buffer contents need not be cleared, because stored_count=0 makes them unreadable.

Structure
REQ-034 Package sensor_pkg SHALL hold DEPTH, WIDTH and the state enumeration.
REQ-035 Storage, wr_ptr and stored_count SHALL live in sub-module temp_ring_buffer, which has one write port and one combinational read port addressed by age.

Verification
REQ-036 Bench SHALL verify: write 10,20,30,40; request offset=1, count=2, out_ready=1 -> beats 30,20 at T+1, T+2; out_last on 20; stats count=2, min=20, max=30.
REQ-037 Bench SHALL verify: write 3 samples; request offset=0, count=50 -> N=3 beats; offset=5 -> no beats, stats count=0, min=0, max=0.
REQ-038 Bench SHALL verify: write 250 samples valued i mod 256 -> stored_count=200; offset=0, count=200 -> beats 249 down to 50.
REQ-039 Bench SHALL verify: full buffer, offset=0, count=200, out_ready low for 5 cycles with 1 write -> data held stable, overrun=1 in DONE.
REQ-040 Bench SHALL verify: sample_valid=1 in acceptance cycle -> that sample is excluded; reset mid-STREAM -> out_valid=0 next cycle, no stats_valid, stored_count=0.
